// File: rtl/sd_reg_pkg.sv
// Shared definitions for the SD host register-access path: bus widths,
// register offsets, the read-only set and the arbiter state encoding.
package sd_reg_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;

  localparam logic [ADDR_W-1:0] REG_004 = 12'h004;
  localparam logic [ADDR_W-1:0] REG_006 = 12'h006;
  localparam logic [ADDR_W-1:0] REG_008 = 12'h008;
  localparam logic [ADDR_W-1:0] REG_00A = 12'h00A;
  localparam logic [ADDR_W-1:0] REG_00C = 12'h00C;
  localparam logic [ADDR_W-1:0] REG_00E = 12'h00E;
  localparam logic [ADDR_W-1:0] REG_010 = 12'h010;
  localparam logic [ADDR_W-1:0] REG_012 = 12'h012;
  localparam logic [ADDR_W-1:0] REG_024 = 12'h024;
  localparam logic [ADDR_W-1:0] REG_02A = 12'h02A;
  localparam logic [ADDR_W-1:0] REG_030 = 12'h030;
  localparam logic [ADDR_W-1:0] REG_032 = 12'h032;
  localparam logic [ADDR_W-1:0] REG_054 = 12'h054;

  // Registers that accept reads but reject writes.
  localparam int NUM_RO = 2;
  localparam logic [NUM_RO-1:0][ADDR_W-1:0] RO_REGS = {REG_030, REG_024};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RESP  = 3'd3,
    ST_ERR   = 3'd4
  } arb_state_e;

  typedef enum logic {
    GRANT_A = 1'b0,
    GRANT_B = 1'b1
  } grant_e;

endpackage

// File: rtl/reg_addr_decode.sv
// Combinational legality check for a register access: the offset must be
// implemented, and writes to read-only offsets are refused.
module reg_addr_decode
  import sd_reg_pkg::*;
#(
  parameter int AW = ADDR_W
) (
  input  logic [AW-1:0] addr,
  input  logic          wr,
  output logic          legal
);

  logic known;
  logic read_only;

  always_comb begin
    known = 1'b0;
    case (addr)
      AW'(REG_004), AW'(REG_006), AW'(REG_008), AW'(REG_00A),
      AW'(REG_00C), AW'(REG_00E), AW'(REG_010), AW'(REG_012),
      AW'(REG_024), AW'(REG_02A), AW'(REG_030), AW'(REG_032),
      AW'(REG_054): known = 1'b1;
      default:      known = 1'b0;
    endcase
    read_only = 1'b0;
    for (int i = 0; i < NUM_RO; i++) begin
      if (addr == AW'(RO_REGS[i])) read_only = 1'b1;
    end
  end

  assign legal = known && !(wr && read_only);

endmodule

// File: rtl/reg_access_arbiter.sv
// Round-robin arbiter giving the CPU (port A) and the host engine (port B)
// single-transaction access to the SD host register block, with timeout.
module reg_access_arbiter #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ADDR_W         = sd_reg_pkg::ADDR_W,
  parameter int DATA_W         = sd_reg_pkg::DATA_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   a_req,
  input  logic                   a_wr,
  input  logic [ADDR_W-1:0]      a_addr,
  input  logic [DATA_W-1:0]      a_wdata,
  output logic                   a_ack,
  output logic [DATA_W-1:0]      a_rdata,
  output logic                   a_err,
  input  logic                   b_req,
  input  logic                   b_wr,
  input  logic [ADDR_W-1:0]      b_addr,
  input  logic [DATA_W-1:0]      b_wdata,
  output logic                   b_ack,
  output logic [DATA_W-1:0]      b_rdata,
  output logic                   b_err,
  output logic                   reg_req,
  output logic                   reg_wr_valid,
  output logic [ADDR_W-1:0]      reg_addrs,
  output logic [DATA_W-1:0]      reg_wr_data,
  input  logic [DATA_W-1:0]      reg_rd_data,
  input  logic                   reg_ack,
  output logic                   busy,
  output sd_reg_pkg::arb_state_e dbg_state
);
  import sd_reg_pkg::*;

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  arb_state_e        state_q;
  grant_e            last_grant_q, gid_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              a_ack_q, a_err_q, b_ack_q, b_err_q;
  logic [DATA_W-1:0] a_rdata_q, b_rdata_q;
  logic              reg_req_q, reg_wr_valid_q;
  logic [ADDR_W-1:0] reg_addrs_q;
  logic [DATA_W-1:0] reg_wr_data_q;

  grant_e            gid_d;
  logic              grant_d, wr_d, legal_d, timeout_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;
  logic              fire_d, err_d, to_b_d;
  logic [DATA_W-1:0] data_d;

  // Round-robin: on a tie the requester that did not win last time goes next.
  always_comb begin
    grant_d = a_req | b_req;
    if (a_req && b_req) gid_d = (last_grant_q == GRANT_B) ? GRANT_A : GRANT_B;
    else if (a_req)     gid_d = GRANT_A;
    else                gid_d = GRANT_B;
    wr_d    = (gid_d == GRANT_A) ? a_wr    : b_wr;
    addr_d  = (gid_d == GRANT_A) ? a_addr  : b_addr;
    wdata_d = (gid_d == GRANT_A) ? a_wdata : b_wdata;
  end

  reg_addr_decode #(.AW(ADDR_W)) u_decode (
    .addr  (addr_d),
    .wr    (wr_d),
    .legal (legal_d)
  );

  assign timeout_d = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Response launched this edge; it appears on the granted port next cycle.
  always_comb begin
    fire_d = 1'b0;
    err_d  = 1'b0;
    data_d = '0;
    to_b_d = (gid_q == GRANT_B);
    unique case (state_q)
      ST_IDLE: begin
        if (grant_d && !legal_d) begin
          fire_d = 1'b1;
          err_d  = 1'b1;
          to_b_d = (gid_d == GRANT_B);
        end
      end
      ST_WAIT: begin
        if (reg_ack) begin
          fire_d = 1'b1;
          data_d = reg_wr_valid_q ? '0 : reg_rd_data;
        end else if (timeout_d) begin
          fire_d = 1'b1;
          err_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      last_grant_q   <= GRANT_B;
      gid_q          <= GRANT_A;
      cnt_q          <= '0;
      a_ack_q        <= 1'b0;
      a_err_q        <= 1'b0;
      a_rdata_q      <= '0;
      b_ack_q        <= 1'b0;
      b_err_q        <= 1'b0;
      b_rdata_q      <= '0;
      reg_req_q      <= 1'b0;
      reg_wr_valid_q <= 1'b0;
      reg_addrs_q    <= '0;
      reg_wr_data_q  <= '0;
    end else begin
      a_ack_q   <= fire_d && !to_b_d;
      a_err_q   <= fire_d && !to_b_d && err_d;
      a_rdata_q <= (fire_d && !to_b_d) ? data_d : '0;
      b_ack_q   <= fire_d && to_b_d;
      b_err_q   <= fire_d && to_b_d && err_d;
      b_rdata_q <= (fire_d && to_b_d) ? data_d : '0;
      unique case (state_q)
        ST_IDLE: begin
          if (grant_d) begin
            gid_q        <= gid_d;
            last_grant_q <= gid_d;
            if (legal_d) begin
              state_q        <= ST_ISSUE;
              reg_req_q      <= 1'b1;
              reg_wr_valid_q <= wr_d;
              reg_addrs_q    <= addr_d;
              reg_wr_data_q  <= wdata_d;
            end else begin
              state_q <= ST_ERR;
            end
          end
        end
        ST_ISSUE: begin
          state_q <= ST_WAIT;
          cnt_q   <= '0;
        end
        ST_WAIT: begin
          if (reg_ack || timeout_d) begin
            state_q        <= reg_ack ? ST_RESP : ST_ERR;
            reg_req_q      <= 1'b0;
            reg_wr_valid_q <= 1'b0;
            reg_addrs_q    <= '0;
            reg_wr_data_q  <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_RESP, ST_ERR: state_q <= ST_IDLE;
        default:         state_q <= ST_IDLE;
      endcase
    end
  end

  assign a_ack        = a_ack_q;
  assign a_err        = a_err_q;
  assign a_rdata      = a_rdata_q;
  assign b_ack        = b_ack_q;
  assign b_err        = b_err_q;
  assign b_rdata      = b_rdata_q;
  assign reg_req      = reg_req_q;
  assign reg_wr_valid = reg_wr_valid_q;
  assign reg_addrs    = reg_addrs_q;
  assign reg_wr_data  = reg_wr_data_q;
  assign busy         = (state_q != ST_IDLE);
  assign dbg_state    = state_q;

endmodule
